// File: rtl/mem_bus_arbiter.sv
// Shares the external 8-bit memory bus between the CPU core and the DMA/loader port.
// Fixed-timing IDLE -> ACCESS -> DONE sequencer with CPU priority and a DMA anti-starvation limit.
module mem_bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int MAX_HOLD    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpu_req_i,
  input  logic       cpu_wr_i,
  input  logic [7:0] cpu_add_i,
  input  logic [7:0] cpu_wdat_i,
  output logic       cpu_gnt_o,
  output logic       cpu_done_o,
  output logic [7:0] cpu_rdat_o,
  input  logic       dma_req_i,
  input  logic       dma_wr_i,
  input  logic [7:0] dma_add_i,
  input  logic [7:0] dma_wdat_i,
  output logic       dma_gnt_o,
  output logic       dma_done_o,
  output logic [7:0] dma_rdat_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic [7:0] mem_add_o,
  output logic [7:0] mem_wdat_o,
  output logic       mem_oe_o,
  input  logic [7:0] mem_rdat_i
);

  localparam logic [2:0] WaitStates = 3'(WAIT_STATES);
  localparam logic [3:0] MaxHold    = 4'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] holdCnt_q, holdCnt_d;
  logic [2:0] waitCnt_q, waitCnt_d;
  logic       ownerDma_q, ownerDma_d;
  logic       busWr_q, busWr_d;
  logic [7:0] memAdd_q, memAdd_d;
  logic [7:0] memWdat_q, memWdat_d;
  logic [7:0] cpuRdat_q, cpuRdat_d;
  logic [7:0] dmaRdat_q, dmaRdat_d;
  logic       dmaWins;

  // DMA only beats a pending CPU request once the CPU has used up its hold allowance
  assign dmaWins = dma_req_i && (!cpu_req_i || (holdCnt_q == MaxHold));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      holdCnt_q  <= '0;
      waitCnt_q  <= '0;
      ownerDma_q <= 1'b0;
      busWr_q    <= 1'b0;
      memAdd_q   <= '0;
      memWdat_q  <= '0;
      cpuRdat_q  <= '0;
      dmaRdat_q  <= '0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      waitCnt_q  <= waitCnt_d;
      ownerDma_q <= ownerDma_d;
      busWr_q    <= busWr_d;
      memAdd_q   <= memAdd_d;
      memWdat_q  <= memWdat_d;
      cpuRdat_q  <= cpuRdat_d;
      dmaRdat_q  <= dmaRdat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    waitCnt_d  = waitCnt_q;
    ownerDma_d = ownerDma_q;
    busWr_d    = busWr_q;
    memAdd_d   = memAdd_q;
    memWdat_d  = memWdat_q;
    cpuRdat_d  = cpuRdat_q;
    dmaRdat_d  = dmaRdat_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          state_d    = ACCESS;
          waitCnt_d  = '0;
          ownerDma_d = dmaWins;
          if (dmaWins) begin
            busWr_d   = dma_wr_i;
            memAdd_d  = dma_add_i;
            memWdat_d = dma_wdat_i;
            holdCnt_d = '0;
          end else begin
            busWr_d   = cpu_wr_i;
            memAdd_d  = cpu_add_i;
            memWdat_d = cpu_wdat_i;
            if (!dma_req_i)
              holdCnt_d = '0;
            else if (holdCnt_q != MaxHold)
              holdCnt_d = holdCnt_q + 4'd1;
          end
        end
      end
      ACCESS: begin
        if (waitCnt_q == WaitStates) begin
          state_d = DONE;
          if (!busWr_q) begin
            if (ownerDma_q)
              dmaRdat_d = mem_rdat_i;
            else
              cpuRdat_d = mem_rdat_i;
          end
        end else begin
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is decoded from registers only, so nothing flows straight from the inputs
  assign cpu_gnt_o  = (state_q != IDLE) && !ownerDma_q;
  assign dma_gnt_o  = (state_q != IDLE) && ownerDma_q;
  assign cpu_done_o = (state_q == DONE) && !ownerDma_q;
  assign dma_done_o = (state_q == DONE) && ownerDma_q;
  assign mem_rd_o   = (state_q == ACCESS) && !busWr_q;
  assign mem_wr_o   = (state_q == ACCESS) && busWr_q;
  assign mem_oe_o   = (state_q == ACCESS) && busWr_q;
  assign mem_add_o  = memAdd_q;
  assign mem_wdat_o = memWdat_q;
  assign cpu_rdat_o = cpuRdat_q;
  assign dma_rdat_o = dmaRdat_q;

endmodule
